// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-side branch predictor: counter
// encodings, default geometry and the PC index/tag slicing helpers.
package bp_pkg;

    // 2-bit saturating counter encodings; bit 1 set means predict taken.
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Default number of index bits (16-entry table).
    localparam int IDX_BITS_DEFAULT = 4;

    // Table index: word-aligned PC bits directly above the byte offset.
    function automatic logic [31:0] bp_index(input logic [31:0] pc, input int idx_bits);
        return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    // Tag: every PC bit above the index field.
    function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int idx_bits);
        return pc >> (2 + idx_bits);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state for a 2-bit saturating direction counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step toward the observed outcome, holding at either end.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters. Lookup of the fetch PC
// is purely combinational; training from EX resolution lands on the
// rising edge, so a same-cycle lookup always sees pre-edge contents.
// Also keeps saturating branch / mispredict performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS = IDX_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        prediction,
    output logic [31:0] predicted_target,
    input  logic        update_en,
    input  logic        update_is_branch,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_mispredict,
    input  logic        flush,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_BITS-1:0] fetch_idx, upd_idx;
    logic [TAG_BITS-1:0] fetch_tag, upd_tag;
    logic                fetch_hit, upd_hit;
    logic [1:0]          upd_ctr_next;

    assign fetch_idx = IDX_BITS'(bp_index(fetch_pc, IDX_BITS));
    assign fetch_tag = TAG_BITS'(bp_tag(fetch_pc, IDX_BITS));
    assign upd_idx   = IDX_BITS'(bp_index(update_pc, IDX_BITS));
    assign upd_tag   = TAG_BITS'(bp_tag(update_pc, IDX_BITS));

    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Single counter stepper serves the one update port.
    bp_sat_counter u_sat_counter (
        .ctr      (ctr_q[upd_idx]),
        .taken    (update_taken),
        .ctr_next (upd_ctr_next)
    );

    // Zero-latency lookup; a miss or weak/strong not-taken falls through to pc+4.
    always_comb begin
        prediction       = fetch_hit && ctr_q[fetch_idx][1];
        predicted_target = prediction ? target_q[fetch_idx] : fetch_pc + 32'd4;
    end

    // Table training; flush wins over any update arriving in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (update_en) begin
            if (update_is_branch) begin
                if (upd_hit) begin
                    ctr_q[upd_idx] <= upd_ctr_next;
                    if (update_taken) target_q[upd_idx] <= update_target;
                end else if (update_taken) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= update_target;
                    ctr_q[upd_idx]    <= CTR_WT;
                end
            end else if (upd_hit) begin
                // A non-branch matched this entry: it is an alias, drop it.
                valid_q[upd_idx] <= 1'b0;
            end
        end
    end

    // Performance counter next-state, saturating at all-ones.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (update_en && update_is_branch) begin
            if (branch_count_q != '1) branch_count_d = branch_count_q + 32'd1;
            if (update_mispredict && (mispredict_count_q != '1))
                mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    // Performance counter registers; unaffected by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios then random traffic,
// checked against a behavioural table model through an expected queue.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        prediction;
    logic [31:0] predicted_target;
    logic        update_en = 1'b0;
    logic        update_is_branch = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        update_mispredict = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;

    // {prediction, predicted_target, branch_count, mispredict_count}
    logic [96:0] exp_q[$];

    // Behavioural model: 16 entries, index = (pc/4)%16, tag = pc/64.
    bit          m_valid  [16];
    logic [31:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    logic [31:0] m_bc, m_mc;

    branch_predictor dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_pc          (fetch_pc),
        .prediction        (prediction),
        .predicted_target  (predicted_target),
        .update_en         (update_en),
        .update_is_branch  (update_is_branch),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .flush             (flush),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 1;
        end
        m_bc = '0; m_mc = '0;
    endtask

    function automatic logic [96:0] model_expect(input logic [31:0] pc);
        int   i;
        bit   hit, pred;
        logic [31:0] tgt;
        i    = m_idx(pc);
        hit  = m_valid[i] && (m_tag[i] == pc / 64);
        pred = hit && (m_ctr[i] >= 2);
        tgt  = pred ? m_target[i] : pc + 32'd4;
        return {pred, tgt, m_bc, m_mc};
    endfunction

    task automatic model_update(input bit ue, input bit ib, input logic [31:0] upc,
                                input bit tk, input logic [31:0] tgt, input bit mp, input bit fl);
        int i;
        bit hit;
        if (ue && ib) begin
            if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
            if (mp && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
        end
        if (fl) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
        end else if (ue) begin
            i   = m_idx(upc);
            hit = m_valid[i] && (m_tag[i] == upc / 64);
            if (ib && hit) begin
                m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                              : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                if (tk) m_target[i] = tgt;
            end else if (ib && tk) begin
                m_valid[i] = 1; m_tag[i] = upc / 64; m_target[i] = tgt; m_ctr[i] = 2;
            end else if (!ib && hit) begin
                m_valid[i] = 0;
            end
        end
    endtask

    // ---------------- driver ----------------
    // Called at posedge+2: drive, queue expected lookup, train model at the edge.
    task automatic drive(input bit ue, input bit ib, input logic [31:0] upc, input bit tk,
                         input logic [31:0] tgt, input bit mp, input bit fl,
                         input logic [31:0] fpc);
        update_en = ue; update_is_branch = ib; update_pc = upc; update_taken = tk;
        update_target = tgt; update_mispredict = mp; flush = fl; fetch_pc = fpc;
        exp_q.push_back(model_expect(fpc));
        @(posedge clk);
        model_update(ue, ib, upc, tk, tgt, mp, fl);
        #2;
    endtask

    task automatic look(input logic [31:0] fpc);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 0, fpc);
    endtask

    task automatic br(input logic [31:0] upc, input bit tk, input logic [31:0] tgt,
                      input bit mp, input logic [31:0] fpc);
        drive(1, 1, upc, tk, tgt, mp, 0, fpc);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        update_en = 0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [96:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("prediction",       {31'd0, prediction}, {31'd0, e[96]});
                check("predicted_target", predicted_target, e[95:64]);
                check("branch_count",     branch_count,     e[63:32]);
                check("mispredict_count", mispredict_count, e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pc_a, pc_b;
        model_reset();
        do_reset();

        // reset state lookup
        look(32'h40);
        // allocate then predict; alias at same index misses
        br(32'h40, 1, 32'h100, 0, 32'h40);
        look(32'h40);
        look(32'h80);
        // hysteresis walk
        br(32'h40, 0, 32'h0, 1, 32'h40);
        look(32'h40);
        br(32'h40, 1, 32'h100, 0, 32'h40);
        br(32'h40, 1, 32'h100, 0, 32'h40);
        br(32'h40, 1, 32'h100, 0, 32'h40);
        br(32'h40, 0, 32'h0, 1, 32'h40);
        look(32'h40);
        // same-cycle read/write sees old contents
        br(32'h40, 0, 32'h0, 1, 32'h40);
        look(32'h40);
        // flush overrides a simultaneous allocation
        br(32'h200, 1, 32'h300, 0, 32'h200);
        br(32'h40, 1, 32'h140, 0, 32'h40);
        drive(1, 1, 32'h280, 1, 32'h900, 0, 1, 32'h40);
        look(32'h40);
        look(32'h200);
        look(32'h280);
        // fall-through wraps at the top of the address space
        look(32'hFFFF_FFFC);
        // non-branch aliasing a live entry invalidates it
        br(32'h500, 1, 32'h600, 0, 32'h500);
        look(32'h500);
        drive(1, 0, 32'h500, 0, 32'h0, 1, 0, 32'h500);
        look(32'h500);

        // counters: 5 branches (2 mispredicted) and one non-branch
        do_reset();
        br(32'h300, 1, 32'h10, 1, 32'h0);
        br(32'h304, 0, 32'h0, 0, 32'h0);
        br(32'h308, 1, 32'h20, 0, 32'h0);
        drive(1, 0, 32'h30C, 1, 32'h0, 1, 0, 32'h0);
        br(32'h310, 0, 32'h0, 1, 32'h0);
        drive(0, 1, 32'h314, 1, 32'h0, 1, 0, 32'h0);
        br(32'h318, 1, 32'h30, 0, 32'h300);
        look(32'h300);
        check("plan_branch_count", branch_count, 32'd5);
        check("plan_mispredict_count", mispredict_count, 32'd2);
        // asynchronous reset mid-cycle
        rst = 1'b0;
        #1;
        check("async_branch_count", branch_count, 32'd0);
        check("async_mispredict_count", mispredict_count, 32'd0);
        check("async_prediction", {31'd0, prediction}, 32'd0);
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        #2;
        look(32'h300);

        // random traffic over a small address pool to force hits and aliases
        for (int n = 0; n < 300; n++) begin
            pc_a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            pc_b = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                 : (($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, pc_a,
                  $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, pc_b);
        end

        update_en = 0; flush = 0;
        repeat (2) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor for the RV32I pipeline. It sits upstream of the IF/ID pipeline register, beside the PC register and the PC-select mux.
- Looks up the current fetch PC combinationally and produces `prediction` and `predicted_target`. These drive the PC mux and the IF/ID `prediction_in`.
- Structure: direct-mapped BTB plus 2-bit saturating counters per entry.
- Trained by branch resolution from EX. Also keeps branch and mispredict performance counters.

Parameters:
- IDX_BITS, 4, index width; ENTRIES = 2**IDX_BITS.
- TAG_BITS, 26, fixed at 30-IDX_BITS; tag = pc[31:2+IDX_BITS].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- fetch_pc  in  32  current PC register output.
- prediction  out  1  1 = predict taken.
- predicted_target  out  32  next fetch address.
- update_en  in  1  EX-stage resolution valid this cycle.
- update_is_branch  in  1  resolved instruction is a branch or jump.
- update_pc  in  32  PC of the resolved instruction.
- update_taken  in  1  actual outcome.
- update_target  in  32  actual target.
- update_mispredict  in  1  EX detected a misprediction.
- flush  in  1  synchronous invalidate-all.
- branch_count  out  32  resolved branches.
- mispredict_count  out  32  mispredictions.

Behaviour:
- Index: idx = pc[IDX_BITS+1:2].
- State per entry: valid, tag, target[31:0], ctr[1:0].
- Reset (rst=0, asynchronous):
  - all valid=0, ctr=2'b01 (weakly not-taken), target=0, tag=0.
  - branch_count=0, mispredict_count=0.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==fetch_pc tag.
  - prediction = hit && ctr[idx][1].
  - predicted_target = prediction ? target[idx] : fetch_pc+4, with a 32-bit wrap (0xFFFFFFFC+4 = 0).
- No write-to-read bypass: a lookup in the same cycle as an update to the same index sees the pre-edge contents.
- Update (rising edge, when update_en=1; applies only if flush=0):
  - is_branch=1, hit at update_pc:
    - ctr increments if taken, decrements if not, saturating at 2'b11 and 2'b00.
    - target := update_target when taken.
  - is_branch=1, miss, taken:
    - allocate: valid=1, tag, target := update_target, ctr := 2'b10 (weakly taken).
    - Replaces any occupant of that index.
  - is_branch=1, miss, not taken: no table change.
  - is_branch=0, hit (aliasing entry): valid := 0.
  - is_branch=0, miss: no change.
- Performance counters (independent of flush):
  - branch_count += 1 when update_en && update_is_branch.
  - mispredict_count += 1 when update_en && update_is_branch && update_mispredict.
  - Both saturate at 0xFFFFFFFF.
  - update_mispredict is ignored when update_en=0.
- flush=1 at an edge:
  - clears every valid bit; ctr and target are left unchanged.
  - Overrides any simultaneous table update, so no allocation happens that cycle.
- Reset mid-operation clears all state immediately, regardless of clk.

Decomposition:
- Shared package `bp_pkg`:
  - counter encodings CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - default IDX_BITS.
  - the index/tag slice helper.
- Sub-module `bp_sat_counter`:
  - combinational next-state for a 2-bit saturating counter.
  - inputs: ctr, taken. Output: ctr_next.
  - instantiated once for the update path.

Test Plan:
1. Reset then lookup: rst=0→1, fetch_pc=0x40 → prediction=0, predicted_target=0x44, branch_count=0, mispredict_count=0.
2. Allocate and predict: update pc=0x40, taken=1, target=0x100 → next cycle fetch_pc=0x40 gives prediction=1, predicted_target=0x100. fetch_pc=0x80 (same idx, different tag) gives prediction=0, predicted_target=0x84.
3. Hysteresis: after test 2 (ctr=10), one not-taken update → ctr=01, prediction=0. Two taken updates → ctr=11. Another taken update keeps ctr=11. One not-taken update → ctr=10, prediction still 1.
4. Same-cycle read/write: fetch_pc=0x40 while updating 0x40 not-taken from ctr=10 → prediction=1 that cycle, 0 the next.
5. Flush priority: flush=1 together with a taken update at 0x200 → no entry hits afterwards (0x40 and 0x200 both give prediction=0); branch_count still increments by 1.
6. Counters and async reset: 5 branch updates, 2 with mispredict=1, plus one update_en with is_branch=0 → branch_count=5, mispredict_count=2. Asserting rst mid-cycle clears both counters before the next clk edge.
